// File: rtl/chess_clock_sched.sv
// Two-player chess game-clock scheduler.
// Holds BCD MM:SS total clocks for RED and BLK and one shared round clock for the
// active player. Sequences IDLE/RUN/PAUSE/SWITCH/TIMEOUT. A single prescaler
// produces the 1 s tick that counts down whichever player is active.
module chess_clock_sched #(
  parameter int unsigned TICKS_PER_SEC = 100,
  parameter logic [15:0] TOTAL_INIT    = 16'h1000,
  parameter logic [15:0] ROUND_MAX     = 16'h0100,
  parameter logic [15:0] ROUND_MIN     = 16'h0015
) (
  input  logic        clk_100Hz,
  input  logic        rst_n,
  input  logic        start,
  input  logic        move_req,
  input  logic        swap,
  output logic        move_ack,
  output logic        turn,
  output logic        run,
  output logic [15:0] total_red,
  output logic [15:0] total_blk,
  output logic [15:0] round_clk,
  output logic [15:0] clock,
  output logic        times_up,
  output logic        loser,
  output logic [2:0]  state
);

  // Round clock reload: clamp a total into [ROUND_MIN, ROUND_MAX]. Unsigned compare
  // of packed BCD words orders MM:SS values correctly.
  function automatic logic [15:0] reload(input logic [15:0] t);
    logic [15:0] r;
    if (t > ROUND_MAX) begin
      r = ROUND_MAX;
    end else if (t > ROUND_MIN) begin
      r = t;
    end else begin
      r = ROUND_MIN;
    end
    return r;
  endfunction

  // One-second BCD MM:SS decrement, saturating at 00:00. Seconds units borrow from
  // seconds tens (wrapping 0 -> 5), which borrow from minutes.
  function automatic logic [15:0] bcd_dec_sat(input logic [15:0] t);
    logic [3:0] mt, mu, st, su;
    {mt, mu, st, su} = t;
    if (t != 16'h0000) begin
      if (su != 4'd0) begin
        su = su - 4'd1;
      end else begin
        su = 4'd9;
        if (st != 4'd0) begin
          st = st - 4'd1;
        end else begin
          st = 4'd5;
          if (mu != 4'd0) begin
            mu = mu - 4'd1;
          end else begin
            mu = 4'd9;
            mt = mt - 4'd1;
          end
        end
      end
    end
    return {mt, mu, st, su};
  endfunction

  localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [15:0]   ROUND_INIT = reload(TOTAL_INIT);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PAUSE   = 3'd2,
    ST_SWITCH  = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic          turn_q, turn_d;
  logic          loser_q, loser_d;
  logic          show_q, show_d;
  logic          req_armed_q, req_armed_d;
  logic          run_q, run_d;
  logic          move_ack_q, move_ack_d;
  logic          times_up_q, times_up_d;
  logic [15:0]   total_red_q, total_red_d;
  logic [15:0]   total_blk_q, total_blk_d;
  logic [15:0]   round_q, round_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          sec_tick;
  logic          reinit;

  // Next-state and datapath: prescaler, countdown, turn switch and timeout handling.
  always_comb begin
    state_d     = state_q;
    turn_d      = turn_q;
    loser_d     = loser_q;
    show_d      = show_q ^ swap;
    req_armed_d = req_armed_q | ~move_req;
    total_red_d = total_red_q;
    total_blk_d = total_blk_q;
    round_d     = round_q;
    presc_d     = presc_q;
    sec_tick    = 1'b0;
    reinit      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        presc_d = '0;
        if (start) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        sec_tick = (presc_q == PRESC_LAST);
        presc_d  = sec_tick ? '0 : presc_q + PW'(1);
        if (sec_tick) begin
          if (turn_q) begin
            total_blk_d = bcd_dec_sat(total_blk_q);
          end else begin
            total_red_d = bcd_dec_sat(total_red_q);
          end
          round_d = bcd_dec_sat(round_q);
        end
        // Expiry beats a pause or a move landing on the same cycle.
        if (sec_tick && (round_q == 16'h0001)) begin
          state_d = ST_TIMEOUT;
          loser_d = turn_q;
        end else if (start) begin
          state_d = ST_PAUSE;
        end else if (move_req && req_armed_q) begin
          state_d = ST_SWITCH;
        end
      end

      ST_PAUSE: begin
        if (start) begin
          state_d = ST_RUN;
        end
      end

      ST_SWITCH: begin
        // Hand the round clock to the incoming player; the request must drop
        // before another switch is accepted.
        presc_d     = '0;
        turn_d      = ~turn_q;
        round_d     = reload(turn_q ? total_red_q : total_blk_q);
        show_d      = 1'b0;
        req_armed_d = 1'b0;
        state_d     = ST_RUN;
      end

      ST_TIMEOUT: begin
        if (start) begin
          reinit = 1'b1;
        end
      end

      default: begin
        reinit = 1'b1;
      end
    endcase

    if (reinit) begin
      state_d     = ST_IDLE;
      turn_d      = 1'b0;
      loser_d     = 1'b0;
      show_d      = 1'b0;
      req_armed_d = 1'b1;
      total_red_d = TOTAL_INIT;
      total_blk_d = TOTAL_INIT;
      round_d     = ROUND_INIT;
      presc_d     = '0;
    end

    run_d      = (state_d == ST_RUN);
    move_ack_d = (state_d == ST_SWITCH);
    times_up_d = (state_d == ST_TIMEOUT);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_100Hz) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      turn_q      <= 1'b0;
      loser_q     <= 1'b0;
      show_q      <= 1'b0;
      req_armed_q <= 1'b1;
      run_q       <= 1'b0;
      move_ack_q  <= 1'b0;
      times_up_q  <= 1'b0;
      total_red_q <= TOTAL_INIT;
      total_blk_q <= TOTAL_INIT;
      round_q     <= ROUND_INIT;
      presc_q     <= '0;
    end else begin
      state_q     <= state_d;
      turn_q      <= turn_d;
      loser_q     <= loser_d;
      show_q      <= show_d;
      req_armed_q <= req_armed_d;
      run_q       <= run_d;
      move_ack_q  <= move_ack_d;
      times_up_q  <= times_up_d;
      total_red_q <= total_red_d;
      total_blk_q <= total_blk_d;
      round_q     <= round_d;
      presc_q     <= presc_d;
    end
  end

  assign move_ack  = move_ack_q;
  assign turn      = turn_q;
  assign run       = run_q;
  assign times_up  = times_up_q;
  assign loser     = loser_q;
  assign total_red = total_red_q;
  assign total_blk = total_blk_q;
  assign round_clk = round_q;
  assign state     = state_q;
  assign clock     = show_q ? (turn_q ? total_blk_q : total_red_q) : round_q;

endmodule

// File: tb/tb_chess_clock_sched.sv
// Bench for chess_clock_sched: two instances (10:00 and 00:20 budgets) share the
// same stimulus; a seconds-based model of the game rules predicts every output.
module tb_chess_clock_sched;

  localparam int T = 4;

  logic clk;
  logic rst_n;
  logic start;
  logic move_req;
  logic swap;

  logic        o_ack   [2];
  logic        o_turn  [2];
  logic        o_run   [2];
  logic        o_tup   [2];
  logic        o_loser [2];
  logic [15:0] o_tred  [2];
  logic [15:0] o_tblk  [2];
  logic [15:0] o_round [2];
  logic [15:0] o_clock [2];
  logic [2:0]  o_state [2];

  chess_clock_sched #(.TICKS_PER_SEC(T), .TOTAL_INIT(16'h1000)) dut_a (
    .clk_100Hz(clk), .rst_n(rst_n), .start(start), .move_req(move_req), .swap(swap),
    .move_ack(o_ack[0]), .turn(o_turn[0]), .run(o_run[0]), .total_red(o_tred[0]),
    .total_blk(o_tblk[0]), .round_clk(o_round[0]), .clock(o_clock[0]),
    .times_up(o_tup[0]), .loser(o_loser[0]), .state(o_state[0]));

  chess_clock_sched #(.TICKS_PER_SEC(T), .TOTAL_INIT(16'h0020)) dut_b (
    .clk_100Hz(clk), .rst_n(rst_n), .start(start), .move_req(move_req), .swap(swap),
    .move_ack(o_ack[1]), .turn(o_turn[1]), .run(o_run[1]), .total_red(o_tred[1]),
    .total_blk(o_tblk[1]), .round_clk(o_round[1]), .clock(o_clock[1]),
    .times_up(o_tup[1]), .loser(o_loser[1]), .state(o_state[1]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Model state, times held as integer seconds.
  int m_mode  [2];
  int m_turn  [2];
  int m_loser [2];
  int m_show  [2];
  int m_armed [2];
  int m_cnt   [2];
  int m_rnd   [2];
  int m_tot   [2][2];
  int init_s  [2] = '{600, 20};
  bit mvalid = 1'b0;

  function automatic int reload_s(input int t);
    return (t > 60) ? 60 : ((t > 15) ? t : 15);
  endfunction

  function automatic logic [15:0] to_bcd(input int s);
    int mm, ss;
    mm = s / 60;
    ss = s % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  task automatic chk(input int inst, input string name, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL dut%0d %s got %h expected %h at %0t", inst, name, got, exp, $time);
    end
  endtask

  task automatic reinit(input int i);
    m_mode[i]   = 0;
    m_turn[i]   = 0;
    m_loser[i]  = 0;
    m_show[i]   = 0;
    m_armed[i]  = 1;
    m_cnt[i]    = 0;
    m_tot[i][0] = init_s[i];
    m_tot[i][1] = init_s[i];
    m_rnd[i]    = reload_s(init_s[i]);
  endtask

  // Advance the game rules by one clock using the inputs present at the edge.
  task automatic step(input int i);
    int  nm, nshow, narmed;
    bit  tick;
    nm     = m_mode[i];
    nshow  = m_show[i] ^ int'(swap);
    narmed = (m_armed[i] != 0 || !move_req) ? 1 : 0;
    case (m_mode[i])
      0: begin
        m_cnt[i] = 0;
        if (start) nm = 1;
      end
      1: begin
        tick = (m_cnt[i] == T - 1);
        m_cnt[i] = tick ? 0 : m_cnt[i] + 1;
        if (tick && m_rnd[i] == 1) begin
          nm = 4;
          m_loser[i] = m_turn[i];
        end else if (start) begin
          nm = 2;
        end else if (move_req && m_armed[i] != 0) begin
          nm = 3;
        end
        if (tick) begin
          if (m_tot[i][m_turn[i]] > 0) m_tot[i][m_turn[i]] -= 1;
          if (m_rnd[i] > 0) m_rnd[i] -= 1;
        end
      end
      2: begin
        if (start) nm = 1;
      end
      3: begin
        m_cnt[i]  = 0;
        m_turn[i] = 1 - m_turn[i];
        m_rnd[i]  = reload_s(m_tot[i][m_turn[i]]);
        nshow     = 0;
        narmed    = 0;
        nm        = 1;
      end
      default: begin
        if (start) begin
          reinit(i);
          return;
        end
      end
    endcase
    m_mode[i]  = nm;
    m_show[i]  = nshow;
    m_armed[i] = narmed;
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      chk(i, "state",     16'(o_state[i]), 16'(m_mode[i]));
      chk(i, "run",       16'(o_run[i]),   16'(m_mode[i] == 1));
      chk(i, "move_ack",  16'(o_ack[i]),   16'(m_mode[i] == 3));
      chk(i, "times_up",  16'(o_tup[i]),   16'(m_mode[i] == 4));
      chk(i, "turn",      16'(o_turn[i]),  16'(m_turn[i]));
      chk(i, "total_red", o_tred[i],       to_bcd(m_tot[i][0]));
      chk(i, "total_blk", o_tblk[i],       to_bcd(m_tot[i][1]));
      chk(i, "round_clk", o_round[i],      to_bcd(m_rnd[i]));
      chk(i, "clock",     o_clock[i],
          (m_show[i] != 0) ? to_bcd(m_tot[i][m_turn[i]]) : to_bcd(m_rnd[i]));
      if (m_mode[i] == 4) chk(i, "loser", 16'(o_loser[i]), 16'(m_loser[i]));
    end
  endtask

  // One clock: model follows the edge, outputs are compared on the falling edge.
  task automatic cyc();
    @(posedge clk);
    if (!rst_n) begin
      reinit(0);
      reinit(1);
      mvalid = 1'b1;
    end else if (mvalid) begin
      step(0);
      step(1);
    end
    @(negedge clk);
    if (mvalid) compare_all();
  endtask

  int acks;

  initial begin
    rst_n = 1'b0; start = 1'b0; move_req = 1'b0; swap = 1'b0;
    cyc();
    rst_n = 1'b1;
    // Reset values.
    chk(0, "rst_state", 16'(o_state[0]), 16'd0);
    chk(0, "rst_tred",  o_tred[0],  16'h1000);
    chk(0, "rst_round", o_round[0], 16'h0100);
    chk(0, "rst_clock", o_clock[0], 16'h0100);
    chk(1, "rst_round", o_round[1], 16'h0020);

    // First second of RED's clock: start cycle, then 4 RUN cycles.
    start = 1'b1; cyc(); start = 1'b0;
    repeat (4) cyc();
    chk(0, "t1_state", 16'(o_state[0]), 16'd1);
    chk(0, "t1_tred",  o_tred[0],  16'h0959);
    chk(0, "t1_round", o_round[0], 16'h0059);
    chk(0, "t1_tblk",  o_tblk[0],  16'h1000);

    // 12 RUN cycles total (3 ticks), then a move.
    repeat (8) cyc();
    move_req = 1'b1;
    cyc();
    chk(0, "t2_ack_hi",  16'(o_ack[0]),   16'd1);
    chk(0, "t2_state_sw", 16'(o_state[0]), 16'd3);
    cyc();
    chk(0, "t2_ack_lo", 16'(o_ack[0]),  16'd0);
    chk(0, "t2_turn",   16'(o_turn[0]), 16'd1);
    chk(0, "t2_round",  o_round[0],     16'h0100);
    chk(0, "t2_tred",   o_tred[0],      16'h0957);
    acks = 0;
    repeat (10) begin
      cyc();
      if (o_ack[0]) acks++;
    end
    chk(0, "t2_no_double_ack", 16'(acks), 16'd0);

    // Prescaler is now at 2: pause, stay frozen, resume; tick lands 2 cycles later.
    move_req = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    chk(0, "t3_paused", 16'(o_state[0]), 16'd2);
    repeat (20) cyc();
    chk(0, "t3_state", 16'(o_state[0]), 16'd2);
    chk(0, "t3_tblk",  o_tblk[0],  16'h0958);
    chk(0, "t3_round", o_round[0], 16'h0058);
    chk(0, "t3_tred",  o_tred[0],  16'h0957);
    start = 1'b1; cyc(); start = 1'b0;
    chk(0, "t3_resumed", 16'(o_state[0]), 16'd1);
    chk(0, "t3_round_hold", o_round[0], 16'h0058);
    cyc();
    chk(0, "t3_round_tick", o_round[0], 16'h0057);
    chk(0, "t3_tblk_tick",  o_tblk[0],  16'h0957);
    swap = 1'b1; cyc(); swap = 1'b0;
    chk(0, "swap_total", o_clock[0], 16'h0957);
    swap = 1'b1; cyc(); swap = 1'b0;
    chk(0, "swap_round", o_clock[0], 16'h0057);

    // Reset for a single edge mid-game after a switch.
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    chk(0, "t6_state", 16'(o_state[0]), 16'd0);
    chk(0, "t6_turn",  16'(o_turn[0]),  16'd0);
    chk(0, "t6_tred",  o_tred[0],  16'h1000);
    chk(0, "t6_tblk",  o_tblk[0],  16'h1000);
    chk(0, "t6_round", o_round[0], 16'h0100);
    chk(0, "t6_run",   16'(o_run[0]),  16'd0);

    // Short budget instance runs out after 20 s = 80 RUN cycles.
    start = 1'b1; cyc(); start = 1'b0;
    repeat (80) cyc();
    chk(1, "t4_state", 16'(o_state[1]), 16'd4);
    chk(1, "t4_tup",   16'(o_tup[1]),   16'd1);
    chk(1, "t4_loser", 16'(o_loser[1]), 16'd0);
    chk(1, "t4_round", o_round[1], 16'h0000);
    chk(1, "t4_tred",  o_tred[1],  16'h0000);
    chk(0, "t4_a_tred", o_tred[0], 16'h0940);
    start = 1'b1; cyc(); start = 1'b0;
    chk(1, "t4_idle",  16'(o_state[1]), 16'd0);
    chk(1, "t4_tred_init", o_tred[1], 16'h0020);
    chk(1, "t4_round_init", o_round[1], 16'h0020);
    chk(1, "t4_tup_lo", 16'(o_tup[1]), 16'd0);

    // Move arrives on the very tick that expires the round clock.
    start = 1'b1; cyc(); start = 1'b0;
    repeat (79) cyc();
    chk(1, "t5_round_one", o_round[1], 16'h0001);
    move_req = 1'b1;
    cyc();
    chk(1, "t5_state", 16'(o_state[1]), 16'd4);
    chk(1, "t5_ack",   16'(o_ack[1]),   16'd0);
    chk(1, "t5_turn",  16'(o_turn[1]),  16'd0);
    cyc();
    chk(1, "t5_ack_after", 16'(o_ack[1]), 16'd0);
    move_req = 1'b0;

    // Randomised play checked against the model every cycle.
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      start = ($urandom % 40) == 0;
      swap  = ($urandom % 8) == 0;
      if (($urandom % 60) == 0) move_req = ~move_req;
      rst_n = ($urandom % 700) != 0;
      cyc();
    end
    start = 1'b0; swap = 1'b0; move_req = 1'b0; rst_n = 1'b1;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
